// File: rtl/jtframe_pdm2pcm.sv
// 1-bit PDM to 16-bit PCM decoder: input synchronizer, modulator feedback bit and
// a 3rd-order CIC decimator by 2^LOG2R with a single-cycle output strobe.
module jtframe_pdm2pcm #(
    parameter int   LOG2R      = 6,
    parameter logic SIGNED_SND = 1'b1
) (
    input  logic        clk_dac,
    input  logic        rst,
    input  logic        cen,
    input  logic        pdm_in,
    output logic        pdm_fb,
    output logic [15:0] pcm,
    output logic        pcm_stb,
    output logic        clip
);
    localparam int L = LOG2R;
    localparam int W = 3*L + 1;
    // Mid-scale of the comb output, 2^(3L-1)
    localparam logic [W-1:0] HALF = {2'b01, {(3*L-1){1'b0}}};

    if (LOG2R < 6 || LOG2R > 8) begin : g_bad_log2r
        $error("jtframe_pdm2pcm: LOG2R must be in 6..8");
    end

    logic         s1_q, s2_q, fb_q;
    logic [W-1:0] i1_q, i2_q, i3_q;
    logic [W-1:0] d1_q, d2_q, d3_q;
    logic [L-1:0] cnt_q;
    logic         tick_q;
    logic [15:0]  pcm_q;
    logic         stb_q, clip_q;

    logic [W-1:0] x, c1, c2, c3, dv;
    logic [15:0]  p, pcm_d;
    logic         sat;

    always_comb begin
        x     = {{(W-1){1'b0}}, s2_q};
        c1    = i3_q - d1_q;
        c2    = c1 - d2_q;
        c3    = c2 - d3_q;
        dv    = c3 - HALF;
        // Only the exact full-scale positive value overflows the 16-bit window
        sat   = (dv == HALF);
        p     = sat ? 16'h7FFF : dv[3*L-1 -: 16];
        pcm_d = SIGNED_SND ? p : {~p[15], p[14:0]};
    end

    // The synchronizer runs every cycle so cen gating never widens its latency
    always_ff @(posedge clk_dac or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pdm_in;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk_dac or posedge rst) begin
        if (rst) begin
            fb_q   <= 1'b0;
            i1_q   <= '0;
            i2_q   <= '0;
            i3_q   <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= cen && (cnt_q == {L{1'b1}});
            if (cen) begin
                fb_q  <= s2_q;
                i1_q  <= i1_q + x;
                i2_q  <= i2_q + i1_q;
                i3_q  <= i3_q + i2_q;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // pcm_stb is a pure strobe: no ready, pcm/clip are valid and stable from it to the next
    always_ff @(posedge clk_dac or posedge rst) begin
        if (rst) begin
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
            pcm_q  <= '0;
            clip_q <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= tick_q;
            if (tick_q) begin
                d1_q   <= i3_q;
                d2_q   <= c1;
                d3_q   <= c2;
                pcm_q  <= pcm_d;
                clip_q <= sat;
            end
        end
    end

    assign pdm_fb  = fb_q;
    assign pcm     = pcm_q;
    assign pcm_stb = stb_q;
    assign clip    = clip_q;
endmodule
